// File: rtl/matrix_op_stream_2x2.sv
// Serial-in / serial-out 2x2 matrix add, subtract, multiply and transpose.
// Eight unsigned operand beats are loaded, one result cycle follows, then four signed result beats.
module matrix_op_stream_2x2 #(
   parameter int unsigned EW = 2,
   localparam int unsigned RW = 2 * EW + 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [EW-1:0] in_data,
   input  logic [1:0]    op,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] out_data,
   output logic          out_last,
   output logic          busy
);

   typedef enum logic [1:0] {StLoad, StCompute, StEmit} state_t;

   state_t        state_q;
   logic [2:0]    cnt_q;
   logic [1:0]    idx_q;
   logic [1:0]    op_q;
   logic [EW-1:0] opnd_q [8];
   logic [RW-1:0] res_q  [4];
   logic [RW-1:0] ext    [8];
   logic [RW-1:0] calc   [4];

   // Combinational so that the block is never ready while reset is held.
   assign in_ready = (state_q == StLoad) && !rst;

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         ext[i] = {{(RW - EW){1'b0}}, opnd_q[i]};
      end
      for (int i = 0; i < 4; i++) begin
         calc[i] = '0;
      end
      // ext[0..3] = a11 a12 a21 a22, ext[4..7] = b11 b12 b21 b22
      case (op_q)
         2'b00: begin
            for (int i = 0; i < 4; i++) calc[i] = ext[i] + ext[i + 4];
         end
         2'b01: begin
            for (int i = 0; i < 4; i++) calc[i] = ext[i] - ext[i + 4];
         end
         2'b10: begin
            calc[0] = ext[0] * ext[4] + ext[1] * ext[6];
            calc[1] = ext[0] * ext[5] + ext[1] * ext[7];
            calc[2] = ext[2] * ext[4] + ext[3] * ext[6];
            calc[3] = ext[2] * ext[5] + ext[3] * ext[7];
         end
         default: begin
            calc[0] = ext[0];
            calc[1] = ext[2];
            calc[2] = ext[1];
            calc[3] = ext[3];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StLoad;
         cnt_q     <= '0;
         idx_q     <= '0;
         op_q      <= '0;
         opnd_q    <= '{default: '0};
         res_q     <= '{default: '0};
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state_q)
            StLoad: begin
               if (in_valid) begin
                  opnd_q[cnt_q] <= in_data;
                  if (cnt_q == 3'd0) begin
                     op_q <= op;
                     busy <= 1'b1;
                  end
                  if (cnt_q == 3'd7) begin
                     cnt_q   <= '0;
                     state_q <= StCompute;
                  end else begin
                     cnt_q <= cnt_q + 3'd1;
                  end
               end
            end
            StCompute: begin
               for (int i = 0; i < 4; i++) res_q[i] <= calc[i];
               out_data  <= calc[0];
               out_valid <= 1'b1;
               out_last  <= 1'b0;
               idx_q     <= '0;
               state_q   <= StEmit;
            end
            StEmit: begin
               if (out_ready) begin
                  if (idx_q == 2'd3) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_data  <= '0;
                     busy      <= 1'b0;
                     state_q   <= StLoad;
                  end else begin
                     idx_q    <= idx_q + 2'd1;
                     out_data <= res_q[idx_q + 2'd1];
                     out_last <= (idx_q == 2'd2);
                  end
               end
            end
            default: state_q <= StLoad;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_op_stream_2x2.sv
// Bench for matrix_op_stream_2x2: fixed vectors, stall/reset sequences and random ops
// compared against a matrix-level reference model.
module tb_matrix_op_stream_2x2;

   localparam int unsigned EW = 2;
   localparam int unsigned RW = 2 * EW + 2;

   typedef struct packed {
      logic [1:0]           op;
      logic [7:0][EW-1:0]   v;
      logic [3:0][RW-1:0]   e;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [EW-1:0] in_data;
   logic [1:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] out_data;
   logic          out_last;
   logic          busy;

   int checks   = 0;
   int failures = 0;
   vec_t tbl [6];

   matrix_op_stream_2x2 #(.EW(EW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] o, input int a11, input int a12, input int a21,
                               input int a22, input int b11, input int b12, input int b21,
                               input int b22, input int c11, input int c12, input int c21,
                               input int c22);
      vec_t m;
      m.op = o;
      m.v[0] = EW'(a11); m.v[1] = EW'(a12); m.v[2] = EW'(a21); m.v[3] = EW'(a22);
      m.v[4] = EW'(b11); m.v[5] = EW'(b12); m.v[6] = EW'(b21); m.v[7] = EW'(b22);
      m.e[0] = RW'(c11); m.e[1] = RW'(c12); m.e[2] = RW'(c21); m.e[3] = RW'(c22);
      return m;
   endfunction

   // Matrix-level reference: row-major A and B, results wrapped to RW bits.
   function automatic logic [3:0][RW-1:0] model(input logic [1:0] o,
                                                input logic [7:0][EW-1:0] v);
      int a [4];
      int b [4];
      int r [4];
      logic [3:0][RW-1:0] res;
      for (int i = 0; i < 4; i++) begin
         a[i] = int'(v[i]);
         b[i] = int'(v[i + 4]);
      end
      for (int row = 0; row < 2; row++) begin
         for (int col = 0; col < 2; col++) begin
            case (o)
               2'b00: r[2*row+col] = a[2*row+col] + b[2*row+col];
               2'b01: r[2*row+col] = a[2*row+col] - b[2*row+col];
               2'b10: r[2*row+col] = a[2*row] * b[col] + a[2*row+1] * b[2+col];
               default: r[2*row+col] = a[2*col+row];
            endcase
         end
      end
      for (int i = 0; i < 4; i++) res[i] = r[i][RW-1:0];
      return res;
   endfunction

   task automatic run_op(input string name, input logic [1:0] op_v,
                         input logic [7:0][EW-1:0] vals, input logic [3:0][RW-1:0] exp_v,
                         input bit gaps, input bit rdy_rand, input bit stall, input int nres);
      int i = 0;
      int k = 0;
      int guard = 0;
      bit hs;
      logic [RW-1:0] d;
      logic l;
      while (i < 8 && guard < 500) begin
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = in_valid ? vals[i] : EW'($urandom);
         op       = (i == 0) ? op_v : 2'($urandom);
         hs = in_valid && in_ready;
         @(posedge clk);
         #1;
         guard++;
         if (hs) i++;
      end
      in_valid = 1'b0;
      chk({name, "_beats"}, i, 8);
      if (i < 8) return;
      chk({name, "_compute_valid"}, int'(out_valid), 0);
      chk({name, "_compute_ready"}, int'(in_ready), 0);
      chk({name, "_busy"}, int'(busy), 1);
      @(posedge clk);
      #1;
      chk({name, "_latency"}, int'(out_valid), 1);
      if (stall) begin
         d = out_data;
         l = out_last;
         out_ready = 1'b0;
         repeat (5) begin
            @(posedge clk);
            #1;
            chk({name, "_stall_valid"}, int'(out_valid), 1);
            chk({name, "_stall_data"}, int'(out_data), int'(d));
            chk({name, "_stall_last"}, int'(out_last), int'(l));
         end
      end
      guard = 0;
      while (k < nres && guard < 500) begin
         out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid && out_ready) begin
            chk($sformatf("%s_data%0d", name, k), int'(out_data), int'(exp_v[k]));
            chk($sformatf("%s_last%0d", name, k), int'(out_last), (k == 3) ? 1 : 0);
            k++;
         end
         @(posedge clk);
         #1;
         guard++;
      end
      out_ready = 1'b0;
      chk({name, "_results"}, k, nres);
      if (nres == 4) begin
         chk({name, "_ready_after"}, int'(in_ready), 1);
         chk({name, "_busy_after"}, int'(busy), 0);
         chk({name, "_valid_after"}, int'(out_valid), 0);
      end
   endtask

   initial begin
      logic [1:0]          rop;
      logic [7:0][EW-1:0]  rv;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      op = '0;
      out_ready = 1'b0;

      tbl[0] = mk(2'b00, 3, 2, 1, 3, 1, 1, 1, 1, 4, 3, 2, 4);
      tbl[1] = mk(2'b01, 3, 2, 1, 3, 1, 1, 1, 1, 2, 1, 0, 2);
      tbl[2] = mk(2'b01, 0, 0, 0, 0, 3, 3, 3, 3, -3, -3, -3, -3);
      tbl[3] = mk(2'b10, 3, 2, 1, 3, 1, 1, 1, 1, 5, 5, 4, 4);
      tbl[4] = mk(2'b10, 3, 3, 3, 3, 3, 3, 3, 3, 18, 18, 18, 18);
      tbl[5] = mk(2'b11, 3, 2, 1, 3, 1, 2, 3, 0, 3, 1, 2, 3);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", int'(in_ready), 1);

      for (int t = 0; t < 6; t++) begin
         run_op($sformatf("vec%0d", t), tbl[t].op, tbl[t].v, tbl[t].e, 1'b0, 1'b0, 1'b0, 4);
      end

      run_op("bp_mul", tbl[3].op, tbl[3].v, tbl[3].e, 1'b1, 1'b0, 1'b1, 4);
      run_op("bp_tr", tbl[5].op, tbl[5].v, tbl[5].e, 1'b1, 1'b1, 1'b1, 4);

      // Reset after five operand beats, then a fresh add of all ones.
      for (int j = 0; j < 5; j++) begin
         in_valid = 1'b1;
         in_data  = 2'd3;
         op       = 2'b10;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rstload_in_ready", int'(in_ready), 0);
      chk("rstload_busy", int'(busy), 0);
      chk("rstload_out_valid", int'(out_valid), 0);
      rst = 1'b0;
      #1;
      run_op("rstload_add", 2'b00, {8{2'd1}}, {4{6'd2}}, 1'b0, 1'b0, 1'b0, 4);

      // Reset in the middle of result emission.
      run_op("rstemit", tbl[0].op, tbl[0].v, tbl[0].e, 1'b0, 1'b0, 1'b0, 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rstemit_out_valid", int'(out_valid), 0);
      chk("rstemit_busy", int'(busy), 0);
      chk("rstemit_out_last", int'(out_last), 0);
      rst = 1'b0;
      #1;
      run_op("rstemit_next", tbl[2].op, tbl[2].v, tbl[2].e, 1'b0, 1'b0, 1'b0, 4);

      for (int t = 0; t < 40; t++) begin
         rop = 2'($urandom);
         for (int j = 0; j < 8; j++) rv[j] = EW'($urandom);
         run_op($sformatf("rnd%0d", t), rop, rv, model(rop, rv), 1'b1, 1'b1, (t % 8) == 0, 4);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
